// File: rtl/sketch_plot_sequencer.sv
// Single source of pixel writes for the etch-a-sketch: turns synchronised key
// requests into cursor plot strobes and runs a full-screen raster clear.
module sketch_plot_sequencer #(
  parameter int         X_MAX         = 159,
  parameter int         Y_MAX         = 119,
  parameter int         START_X       = 80,
  parameter int         START_Y       = 60,
  parameter int         REPEAT_CYCLES = 2500000,
  parameter logic [2:0] BG_COLOUR     = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       dir_up,
  input  logic       dir_down,
  input  logic       dir_left,
  input  logic       dir_right,
  input  logic       clear_req,
  input  logic [2:0] pen_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic [7:0] cursor_x,
  output logic [6:0] cursor_y
);

  localparam int            CW       = $clog2(REPEAT_CYCLES);
  localparam logic [7:0]    X_LAST   = 8'(X_MAX);
  localparam logic [6:0]    Y_LAST   = 7'(Y_MAX);
  localparam logic [7:0]    X_HOME   = 8'(START_X);
  localparam logic [6:0]    Y_HOME   = 7'(START_Y);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_CURSOR = 2'd2;

  logic [4:0] req_async;
  logic [4:0] req_sync;

  assign req_async = {clear_req, dir_right, dir_left, dir_down, dir_up};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= req_async[gi];
          sync_reg <= meta_reg;
        end
      end
      assign req_sync[gi] = sync_reg;
    end
  endgenerate

  // Normalised vector {up, down, left, right}: an opposite pair cancels on its axis.
  logic [3:0] dir_vec;
  logic       clear_edge;

  assign dir_vec = {req_sync[0] & ~req_sync[1],
                    req_sync[1] & ~req_sync[0],
                    req_sync[2] & ~req_sync[3],
                    req_sync[3] & ~req_sync[2]};

  logic [1:0]    state_reg, state_next;
  logic [7:0]    cursor_x_reg, cursor_x_next;
  logic [6:0]    cursor_y_reg, cursor_y_next;
  logic [7:0]    vga_x_reg, vga_x_next;
  logic [6:0]    vga_y_reg, vga_y_next;
  logic [2:0]    vga_colour_reg, vga_colour_next;
  logic          plot_reg, plot_next;
  logic          busy_reg, busy_next;
  logic [CW-1:0] rpt_reg, rpt_next;
  logic [3:0]    dir_prev_reg;
  logic          clear_prev_reg;

  assign clear_edge = req_sync[4] & ~clear_prev_reg;

  // Saturating single step of the cursor along the normalised vector.
  logic [7:0] step_x;
  logic [6:0] step_y;

  always_comb begin
    step_x = cursor_x_reg;
    step_y = cursor_y_reg;
    if (dir_vec[0] && (cursor_x_reg < X_LAST)) begin
      step_x = cursor_x_reg + 8'd1;
    end else if (dir_vec[1] && (cursor_x_reg != 8'd0)) begin
      step_x = cursor_x_reg - 8'd1;
    end
    if (dir_vec[2] && (cursor_y_reg < Y_LAST)) begin
      step_y = cursor_y_reg + 7'd1;
    end else if (dir_vec[3] && (cursor_y_reg != 7'd0)) begin
      step_y = cursor_y_reg - 7'd1;
    end
  end

  logic step;

  always_comb begin
    state_next      = state_reg;
    cursor_x_next   = cursor_x_reg;
    cursor_y_next   = cursor_y_reg;
    vga_x_next      = vga_x_reg;
    vga_y_next      = vga_y_reg;
    vga_colour_next = vga_colour_reg;
    plot_next       = 1'b0;
    busy_next       = busy_reg;
    rpt_next        = '0;
    step            = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if ((dir_vec != 4'd0) && (dir_vec == dir_prev_reg)) begin
          if (rpt_reg == RPT_LAST) begin
            step = 1'b1;
          end else begin
            rpt_next = rpt_reg + CW'(1);
          end
        end else begin
          step = (dir_vec != 4'd0);
        end

        // A clear edge wins over a step decided in the same cycle.
        if (clear_edge) begin
          state_next      = ST_CLEAR;
          plot_next       = 1'b1;
          busy_next       = 1'b1;
          vga_x_next      = 8'd0;
          vga_y_next      = 7'd0;
          vga_colour_next = BG_COLOUR;
          rpt_next        = '0;
        end else if (step) begin
          cursor_x_next   = step_x;
          cursor_y_next   = step_y;
          plot_next       = 1'b1;
          vga_x_next      = step_x;
          vga_y_next      = step_y;
          vga_colour_next = pen_colour;
        end
      end

      ST_CLEAR: begin
        // vga_x/vga_y double as the raster position of the pixel on the bus.
        plot_next = 1'b1;
        if (vga_x_reg == X_LAST) begin
          vga_x_next = 8'd0;
          if (vga_y_reg == Y_LAST) begin
            state_next      = ST_CURSOR;
            busy_next       = 1'b0;
            cursor_x_next   = X_HOME;
            cursor_y_next   = Y_HOME;
            vga_x_next      = X_HOME;
            vga_y_next      = Y_HOME;
            vga_colour_next = pen_colour;
          end else begin
            vga_y_next = vga_y_reg + 7'd1;
          end
        end else begin
          vga_x_next = vga_x_reg + 8'd1;
        end
      end

      ST_CURSOR: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      cursor_x_reg   <= X_HOME;
      cursor_y_reg   <= Y_HOME;
      vga_x_reg      <= X_HOME;
      vga_y_reg      <= Y_HOME;
      vga_colour_reg <= 3'd0;
      plot_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      rpt_reg        <= '0;
      dir_prev_reg   <= 4'd0;
      clear_prev_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cursor_x_reg   <= cursor_x_next;
      cursor_y_reg   <= cursor_y_next;
      vga_x_reg      <= vga_x_next;
      vga_y_reg      <= vga_y_next;
      vga_colour_reg <= vga_colour_next;
      plot_reg       <= plot_next;
      busy_reg       <= busy_next;
      rpt_reg        <= rpt_next;
      // Tracked in every state so a vector or level held through a clear never looks new.
      dir_prev_reg   <= dir_vec;
      clear_prev_reg <= req_sync[4];
    end
  end

  assign vga_x      = vga_x_reg;
  assign vga_y      = vga_y_reg;
  assign vga_colour = vga_colour_reg;
  assign plot       = plot_reg;
  assign busy       = busy_reg;
  assign cursor_x   = cursor_x_reg;
  assign cursor_y   = cursor_y_reg;

endmodule

// File: tb/tb_sketch_plot_sequencer.sv
// Scoreboard bench for sketch_plot_sequencer: each plot strobe is recorded with
// its cycle number and matched against the expected write queue.
module tb_sketch_plot_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        b;
  } plot_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       dir_up = 1'b0;
  logic       dir_down = 1'b0;
  logic       dir_left = 1'b0;
  logic       dir_right = 1'b0;
  logic       clear_req = 1'b0;
  logic [2:0] pen_colour = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic [7:0] cursor_x;
  logic [6:0] cursor_y;

  localparam logic [2:0] BG = 3'b110;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  plot_t exp_q[$];
  plot_t obs_q[$];
  plot_t mon_p;

  sketch_plot_sequencer #(
    .X_MAX(3), .Y_MAX(2), .START_X(1), .START_Y(1),
    .REPEAT_CYCLES(8), .BG_COLOUR(BG)
  ) dut (
    .clock(clock), .resetn(resetn),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .clear_req(clear_req), .pen_colour(pen_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (plot === 1'b1) begin
      mon_p.cyc = cyc;
      mon_p.x   = vga_x;
      mon_p.y   = vga_y;
      mon_p.c   = vga_colour;
      mon_p.b   = busy;
      obs_q.push_back(mon_p);
    end
  end

  function automatic plot_t mk(input int cy, input int x, input int y, input logic [2:0] c, input logic b);
    plot_t p;
    p.cyc = cy; p.x = 8'(x); p.y = 7'(y); p.c = c; p.b = b;
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0; clear_req = 0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  // Pulse a direction combination for len cycles; c is the cycle it was applied in.
  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input int len, input logic [2:0] pen, output int c);
    @(negedge clock);
    pen_colour = pen;
    dir_up = u; dir_down = d; dir_left = l; dir_right = r;
    c = cyc;
    repeat (len) @(negedge clock);
    dir_up = 0; dir_down = 0; dir_left = 0; dir_right = 0;
    repeat (12) @(negedge clock);
  endtask

  // Push the 12 raster writes plus the cursor redraw for a clear edge applied in cycle c.
  task automatic push_clear(input int c, input logic [2:0] pen);
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x <= 3; x++)
        exp_q.push_back(mk(c + 3 + y * 4 + x, x, y, BG, 1'b1));
    exp_q.push_back(mk(c + 15, 1, 1, pen, 1'b0));
  endtask

  task automatic test_reset();
    plot_t e, o;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got plot=%b busy=%b, required 0 0", plot, busy);
    end
    checks++;
    if (cursor_x !== 8'd1 || cursor_y !== 7'd1) begin
      errors++; $display("FAIL reset_cursor: got (%0d,%0d), required (1,1)", cursor_x, cursor_y);
    end
    checks++;
    if (vga_x !== 8'd1 || vga_y !== 7'd1 || vga_colour !== 3'd0) begin
      errors++; $display("FAIL reset_vga: got (%0d,%0d) colour %0d, required (1,1) colour 0", vga_x, vga_y, vga_colour);
    end
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL reset_noplot: got %0d plots after release, required 0", obs_q.size());
      obs_q.delete();
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = e;
    end
    $display("tb: reset done cursor=(%0d,%0d)", cursor_x, cursor_y);
  endtask

  task automatic test_single_press();
    plot_t e, o;
    int c;
    do_reset();
    @(negedge clock);
    pen_colour = 3'd5; dir_right = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 3, 2, 1, 3'd5, 1'b0));
    repeat (3) @(negedge clock);
    dir_right = 1'b0;
    pen_colour = 3'd0;
    repeat (15) @(negedge clock);
    checks++;
    if (cursor_x !== 8'd2 || cursor_y !== 7'd1) begin
      errors++; $display("FAIL single_cursor: got (%0d,%0d), required (2,1)", cursor_x, cursor_y);
    end
    checks++;
    if (vga_x !== 8'd2 || vga_y !== 7'd1 || vga_colour !== 3'd5) begin
      errors++; $display("FAIL single_hold: got (%0d,%0d) colour %0d, required (2,1) colour 5", vga_x, vga_y, vga_colour);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL single_plot: got none, required cyc=%0d (%0d,%0d) colour %0d", e.cyc, e.x, e.y, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL single_plot: got cyc=%0d (%0d,%0d) colour %0d busy %0d, required cyc=%0d (%0d,%0d) colour %0d busy %0d",
                             o.cyc, o.x, o.y, o.c, o.b, e.cyc, e.x, e.y, e.c, e.b);
        end else $display("tb: single plot cyc=%0d (%0d,%0d) colour %0d", o.cyc, o.x, o.y, o.c);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL single_extra: got %0d unexpected plots, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_hold_saturate();
    plot_t e, o;
    int c;
    int x;
    do_reset();
    @(negedge clock);
    pen_colour = 3'd3; dir_right = 1'b1; c = cyc;
    x = 1;
    for (int k = 0; k < 5; k++) begin
      x = (x < 3) ? x + 1 : 3;
      exp_q.push_back(mk(c + 3 + 8 * k, x, 1, 3'd3, 1'b0));
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      checks++;
      if (cursor_x > 8'd3) begin
        errors++; $display("FAIL hold_bound: got cursor_x=%0d at cyc %0d, required <=3", cursor_x, cyc);
      end
    end
    dir_right = 1'b0;
    repeat (12) @(negedge clock);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL hold_plot: got none, required cyc=%0d (%0d,%0d) colour %0d", e.cyc, e.x, e.y, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL hold_plot: got cyc=%0d (%0d,%0d) colour %0d busy %0d, required cyc=%0d (%0d,%0d) colour %0d busy %0d",
                             o.cyc, o.x, o.y, o.c, o.b, e.cyc, e.x, e.y, e.c, e.b);
        end else $display("tb: hold plot cyc=%0d (%0d,%0d) colour %0d", o.cyc, o.x, o.y, o.c);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL hold_extra: got %0d unexpected plots, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_cancel_diagonal();
    plot_t e, o;
    int c;
    do_reset();
    c = 0;
    press(1, 0, 1, 0, 3, 3'd2, c);           // up+left from (1,1)
    exp_q.push_back(mk(c + 3, 0, 0, 3'd2, 1'b0));
    press(1, 0, 1, 0, 3, 3'd3, c);           // up+left at (0,0): redraw only
    exp_q.push_back(mk(c + 3, 0, 0, 3'd3, 1'b0));
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 7'd0) begin
      errors++; $display("FAIL corner_cursor: got (%0d,%0d), required (0,0)", cursor_x, cursor_y);
    end
    press(1, 1, 0, 1, 3, 3'd4, c);           // up+down cancel, right moves
    exp_q.push_back(mk(c + 3, 1, 0, 3'd4, 1'b0));
    press(1, 0, 0, 1, 3, 3'd6, c);           // up+right on top edge: x only
    exp_q.push_back(mk(c + 3, 2, 0, 3'd6, 1'b0));
    press(0, 1, 1, 0, 3, 3'd7, c);           // down+left: both axes
    exp_q.push_back(mk(c + 3, 1, 1, 3'd7, 1'b0));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL diag_plot: got none, required cyc=%0d (%0d,%0d) colour %0d", e.cyc, e.x, e.y, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL diag_plot: got cyc=%0d (%0d,%0d) colour %0d busy %0d, required cyc=%0d (%0d,%0d) colour %0d busy %0d",
                             o.cyc, o.x, o.y, o.c, o.b, e.cyc, e.x, e.y, e.c, e.b);
        end else $display("tb: diag plot cyc=%0d (%0d,%0d) colour %0d", o.cyc, o.x, o.y, o.c);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL diag_extra: got %0d unexpected plots, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_clear();
    plot_t e, o;
    int c;
    do_reset();
    c = 0;
    press(0, 0, 0, 1, 3, 3'd5, c);
    exp_q.push_back(mk(c + 3, 2, 1, 3'd5, 1'b0));
    @(negedge clock);
    clear_req = 1'b1; c = cyc;
    push_clear(c, 3'd5);
    repeat (3) @(negedge clock);
    clear_req = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL clear_busy: got busy=%b mid-clear, required 1", busy);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || cursor_x !== 8'd1 || cursor_y !== 7'd1) begin
      errors++; $display("FAIL clear_end: got busy=%b cursor (%0d,%0d), required 0 (1,1)", busy, cursor_x, cursor_y);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL clear_plot: got none, required cyc=%0d (%0d,%0d) colour %0d", e.cyc, e.x, e.y, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL clear_plot: got cyc=%0d (%0d,%0d) colour %0d busy %0d, required cyc=%0d (%0d,%0d) colour %0d busy %0d",
                             o.cyc, o.x, o.y, o.c, o.b, e.cyc, e.x, e.y, e.c, e.b);
        end else $display("tb: clear plot cyc=%0d (%0d,%0d) colour %0d busy %0d", o.cyc, o.x, o.y, o.c, o.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL clear_extra: got %0d unexpected plots, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_clear_interactions();
    plot_t e, o;
    int c;
    do_reset();
    // Step request coincident with the clear edge, then move and clear again mid-clear.
    @(negedge clock);
    pen_colour = 3'd7; clear_req = 1'b1; dir_down = 1'b1; c = cyc;
    push_clear(c, 3'd7);
    repeat (3) @(negedge clock);
    clear_req = 1'b0; dir_down = 1'b0;
    repeat (3) @(negedge clock);
    clear_req = 1'b1; dir_down = 1'b1;
    repeat (3) @(negedge clock);
    clear_req = 1'b0; dir_down = 1'b0;
    repeat (30) @(negedge clock);
    // Vector held through the clear steps only after a full repeat period.
    pen_colour = 3'd1; clear_req = 1'b1; dir_right = 1'b1; c = cyc;
    push_clear(c, 3'd1);
    exp_q.push_back(mk(c + 24, 2, 1, 3'd1, 1'b0));
    repeat (3) @(negedge clock);
    clear_req = 1'b0;
    repeat (23) @(negedge clock);
    dir_right = 1'b0;
    repeat (15) @(negedge clock);
    // Reset asserted part-way through the raster.
    clear_req = 1'b1; c = cyc;
    for (int x = 0; x < 3; x++) exp_q.push_back(mk(c + 3 + x, x, 0, BG, 1'b1));
    repeat (3) @(negedge clock);
    clear_req = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_flags: got plot=%b busy=%b, required 0 0", plot, busy);
    end
    checks++;
    if (vga_x !== 8'd1 || vga_y !== 7'd1 || vga_colour !== 3'd0 || cursor_x !== 8'd1 || cursor_y !== 7'd1) begin
      errors++; $display("FAIL abort_values: got vga (%0d,%0d) colour %0d cursor (%0d,%0d), required (1,1) 0 (1,1)",
                         vga_x, vga_y, vga_colour, cursor_x, cursor_y);
    end
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL interact_plot: got none, required cyc=%0d (%0d,%0d) colour %0d", e.cyc, e.x, e.y, e.c);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL interact_plot: got cyc=%0d (%0d,%0d) colour %0d busy %0d, required cyc=%0d (%0d,%0d) colour %0d busy %0d",
                             o.cyc, o.x, o.y, o.c, o.b, e.cyc, e.x, e.y, e.c, e.b);
        end else $display("tb: interact plot cyc=%0d (%0d,%0d) colour %0d busy %0d", o.cyc, o.x, o.y, o.c, o.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL interact_extra: got %0d unexpected plots, required 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_hold_saturate();
    test_cancel_diagonal();
    test_clear();
    test_clear_interactions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
